qmult_seq: RTL and testbench



---
 rtl/qmath_pkg.sv | 7 +
 rtl/qmult_step.sv | 11 +
 rtl/qmult_seq.sv | 101 ++++++++++
 tb/tb_qmult_seq.sv | 124 ++++++++++++
 4 files changed

// File: rtl/qmath_pkg.sv
// qmath_pkg: shared Q-format constants and multiplier state encoding
package qmath_pkg;
  localparam int N_DEF = 32;
  localparam int Q_DEF = 15;
  localparam int SIGN_IDX = N_DEF - 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/qmult_step.sv
// qmult_step: one combinational shift-add step (acc_nxt = lsb ? acc + mcand : acc)
module qmult_step #(
  parameter int W = 62
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] mcand,
  input  logic         lsb,
  output logic [W-1:0] acc_nxt
);
  assign acc_nxt = lsb ? acc + mcand : acc;
endmodule

// File: rtl/qmult_seq.sv
// qmult_seq: sequential sign-magnitude Q(N-1-Q).Q shift-add multiplier with valid/ready handshakes
// ports: clk, rst (sync, active-high); in_valid/in_ready with a, b; out_valid/out_ready with c, ovf
// QMULT_SAT_EN defined: overflow saturates the magnitude to all ones; undefined: it wraps
module qmult_seq
  import qmath_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int Q = Q_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c,
  output logic         ovf
);
  localparam int M = N - 1;
  localparam int W = 2 * M;
  localparam int CW = $clog2(M + 1);
  state_t state_q, state_d;
  logic sign_q, sign_d, ovf_q, ovf_d, hi, last;
  logic [W-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_step;
  logic [M-1:0] mplier_q, mplier_d, mag_raw, mag;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0] c_q, c_d, res;
  qmult_step #(.W(W)) u_step (
    .acc(acc_q),
    .mcand(mcand_q),
    .lsb(mplier_q[0]),
    .acc_nxt(acc_step)
  );
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign c = c_q;
  assign ovf = ovf_q;
  assign last = cnt_q == CW'(M - 1);
  assign mag_raw = acc_step[Q+N-2:Q];
  assign hi = |acc_step[W-1:Q+N-1];
`ifdef QMULT_SAT_EN
  assign mag = hi ? '1 : mag_raw;
`else
  assign mag = mag_raw;
`endif
  // zero magnitude never carries a sign
  assign res = {sign_q & |mag, mag};
  always_comb begin
    state_d = state_q;
    sign_d = sign_q;
    acc_d = acc_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    cnt_d = cnt_q;
    c_d = c_q;
    ovf_d = ovf_q;
    if (state_q == IDLE && in_valid) begin
      state_d = BUSY;
      sign_d = a[N-1] ^ b[N-1];
      acc_d = '0;
      mcand_d = {{M{1'b0}}, a[N-2:0]};
      mplier_d = b[N-2:0];
      cnt_d = '0;
    end else if (state_q == BUSY) begin
      acc_d = acc_step;
      mcand_d = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        state_d = DONE;
        c_d = res;
        ovf_d = hi;
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sign_q <= 1'b0;
      acc_q <= '0;
      mcand_q <= '0;
      mplier_q <= '0;
      cnt_q <= '0;
      c_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q <= sign_d;
      acc_q <= acc_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q <= cnt_d;
      c_q <= c_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: tb/tb_qmult_seq.sv
// tb_qmult_seq: directed vector bench for qmult_seq
module tb_qmult_seq;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic in_ready, out_valid, ovf;
  logic [31:0] c;
  int checks = 0, errors = 0;
  typedef struct {
    logic [31:0] a, b, c;
    logic ovf;
  } vec_t;
  vec_t vecs[10];
  qmult_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .c(c), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic accept(input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    a = av;
    b = bv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 32'hDEADBEEF;
    b = 32'hDEADBEEF;
  endtask
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask
  initial begin
    int lat;
    vecs[0] = '{32'h0000C000, 32'h00010000, 32'h00018000, 1'b0};
    vecs[1] = '{32'h8000C000, 32'h00010000, 32'h80018000, 1'b0};
    vecs[2] = '{32'h8000C000, 32'h80010000, 32'h00018000, 1'b0};
`ifdef QMULT_SAT_EN
    vecs[3] = '{32'h7FFFFFFF, 32'h00010000, 32'h7FFFFFFF, 1'b1};
    vecs[4] = '{32'hFFFFFFFF, 32'h00010000, 32'hFFFFFFFF, 1'b1};
`else
    vecs[3] = '{32'h7FFFFFFF, 32'h00010000, 32'h7FFFFFFE, 1'b1};
    vecs[4] = '{32'hFFFFFFFF, 32'h00010000, 32'hFFFFFFFE, 1'b1};
`endif
    vecs[5] = '{32'h80000000, 32'h00008000, 32'h00000000, 1'b0};
    vecs[6] = '{32'h80000001, 32'h00000001, 32'h00000000, 1'b0};
    vecs[7] = '{32'h00008000, 32'h80008000, 32'h80008000, 1'b0};
    vecs[8] = '{32'h00004000, 32'h00004000, 32'h00002000, 1'b0};
    vecs[9] = '{32'h00000003, 32'h00004000, 32'h00000001, 1'b0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_c", c, 32'h0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      accept(vecs[i].a, vecs[i].b);
      chk($sformatf("v%0d_busy_in_ready", i), 32'(in_ready), 32'd0);
      wait_done(lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd31);
      chk($sformatf("v%0d_c", i), c, vecs[i].c);
      chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_hs_in_ready", i), 32'(in_ready), 32'd1);
      chk($sformatf("v%0d_hs_out_valid", i), 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;
    accept(32'h0000C000, 32'h00010000);
    wait_done(lat);
    chk("bp_latency", 32'(lat), 32'd31);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = 32'h00010000;
      b = 32'h00010000;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp_c_stable", c, 32'h00018000);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    accept(32'h8000C000, 32'h00010000);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_c", c, 32'h0);
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
    accept(32'h00008000, 32'h8000C000);
    wait_done(lat);
    chk("post_rst_latency", 32'(lat), 32'd31);
    chk("post_rst_c", c, 32'h8000C000);
    chk("post_rst_ovf", 32'(ovf), 32'd0);
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
